// File: rtl/ad_emu_pkg.sv
// Shared encodings for the serial ADC slave emulator: sample modes, fx register
// offsets, responder FSM states and the noise LFSR constants.
package ad_emu_pkg;

    typedef enum logic [1:0] {
        MODE_CONST  = 2'd0,
        MODE_RAMP   = 2'd1,
        MODE_TOGGLE = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEAD = 2'd1,
        ST_DATA = 2'd2,
        ST_TAIL = 2'd3
    } state_e;

    localparam logic [15:0] REG_MODE    = 16'h0000;
    localparam logic [15:0] REG_STEP_LO = 16'h0001;
    localparam logic [15:0] REG_STEP_HI = 16'h0002;
    localparam logic [15:0] REG_CONST_LO = 16'h0003;
    localparam logic [15:0] REG_CONST_HI = 16'h0004;
    localparam logic [15:0] REG_FRAMES  = 16'h0005;
    localparam logic [15:0] REG_ABORTS  = 16'h0006;
    localparam logic [15:0] REG_STATUS  = 16'h0007;
    localparam logic [15:0] REG_NOISE   = 16'h0008;

    // Right-shifting Fibonacci form: feedback from bits 0,2,3,5 (taps 16,14,13,11).
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/ad_emu_pat.sv
// Sample word generator: constant, ramp or toggle, advanced once per frame start.
// With AD_EMU_NOISE_EN defined, an LFSR perturbs the low nibble through noise_mask.
module ad_emu_pat
    import ad_emu_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic          advance,
    input  logic          clr,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] step,
    input  logic [DW-1:0] cst,
`ifdef AD_EMU_NOISE_EN
    input  logic [3:0]    noise_mask,
`endif
    output logic [DW-1:0] sample
);

    logic [DW-1:0] acc;
    logic          phase;
    logic [DW-1:0] gen_sample;

    always_comb begin
        gen_sample = cst;
        case (mode)
            MODE_RAMP:   gen_sample = acc;
            MODE_TOGGLE: gen_sample = phase ? ~cst : cst;
            default:     gen_sample = cst;
        endcase
    end

    // A mode write clears the generator even if it lands on a frame start.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            acc   <= '0;
            phase <= 1'b0;
        end else if (clr) begin
            acc   <= '0;
            phase <= 1'b0;
        end else if (advance) begin
            if (mode == MODE_RAMP)   acc   <= acc + step;
            if (mode == MODE_TOGGLE) phase <= ~phase;
        end
    end

`ifdef AD_EMU_NOISE_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk_sys) begin
        if (!rst_n)       lfsr <= LFSR_SEED;
        else if (advance) lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
    end

    assign sample = gen_sample ^ {{(DW-4){1'b0}}, lfsr[3:0] & noise_mask};
`else
    assign sample = gen_sample;
`endif

endmodule

// File: rtl/ad_emu_top.sv
// Serial ADC slave emulator: answers a cs_n/sclk master with programmable sample
// words, configured over the fx bus. Optional noise injection under AD_EMU_NOISE_EN.
module ad_emu_top
    import ad_emu_pkg::*;
#(
    parameter int DW          = 16,
    parameter int LEAD_BITS   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        cs_n,
    input  logic        sclk,
    output logic        sdata,
    input  logic [21:0] fx_waddr,
    input  logic        fx_wr,
    input  logic [7:0]  fx_data,
    input  logic        fx_rd,
    input  logic [21:0] fx_raddr,
    output logic [7:0]  fx_q,
    input  logic [5:0]  dev_id
);

    localparam int CW = $clog2(DW + LEAD_BITS + 1);

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync;
    logic                   cs_d, sclk_d;
    logic                   cs_s, sclk_s, cs_fall, cs_rise, sclk_fall;

    state_e        state, state_nx;
    logic [DW-1:0] shreg, shreg_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          sdata_nx, advance, frame_inc, abort_inc;

    logic [1:0]    mode_reg;
    logic [DW-1:0] step_reg, const_reg, sample;
    logic [7:0]    frame_cnt, abort_cnt, rdata;
    logic          wsel, rsel, mode_wr;
    logic [15:0]   woff;

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            cs_sync   <= '0;
            sclk_sync <= '0;
            cs_d      <= 1'b0;
            sclk_d    <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_d      <= cs_s;
            sclk_d    <= sclk_s;
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_d & ~cs_s;
    assign cs_rise   = ~cs_d & cs_s;
    assign sclk_fall = sclk_d & ~sclk_s;

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            shreg <= '0;
            cnt   <= '0;
            sdata <= 1'b0;
        end else begin
            state <= state_nx;
            shreg <= shreg_nx;
            cnt   <= cnt_nx;
            sdata <= sdata_nx;
        end
    end

    // cnt holds remaining lead falls in LEAD, remaining bits after the current one in DATA.
    always_comb begin
        state_nx  = state;
        shreg_nx  = shreg;
        cnt_nx    = cnt;
        sdata_nx  = sdata;
        advance   = 1'b0;
        frame_inc = 1'b0;
        abort_inc = 1'b0;
        case (state)
            ST_IDLE: begin
                sdata_nx = 1'b0;
                if (cs_fall) begin
                    advance  = 1'b1;
                    shreg_nx = sample;
                    if (LEAD_BITS == 0) begin
                        state_nx = ST_DATA;
                        sdata_nx = sample[DW-1];
                        cnt_nx   = CW'(DW - 1);
                    end else begin
                        state_nx = ST_LEAD;
                        cnt_nx   = CW'(LEAD_BITS);
                    end
                end
            end
            ST_LEAD: begin
                if (cs_rise) begin
                    state_nx  = ST_IDLE;
                    sdata_nx  = 1'b0;
                    abort_inc = 1'b1;
                end else if (sclk_fall) begin
                    if (cnt == CW'(1)) begin
                        state_nx = ST_DATA;
                        sdata_nx = shreg[DW-1];
                        cnt_nx   = CW'(DW - 1);
                    end else begin
                        cnt_nx = cnt - CW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (cs_rise) begin
                    state_nx  = ST_IDLE;
                    sdata_nx  = 1'b0;
                    abort_inc = 1'b1;
                end else if (sclk_fall) begin
                    if (cnt == '0) begin
                        state_nx = ST_TAIL;
                        sdata_nx = 1'b0;
                    end else begin
                        shreg_nx = shreg << 1;
                        sdata_nx = shreg[DW-2];
                        cnt_nx   = cnt - CW'(1);
                    end
                end
            end
            default: begin
                sdata_nx = 1'b0;
                if (cs_rise) begin
                    state_nx  = ST_IDLE;
                    frame_inc = 1'b1;
                end
            end
        endcase
    end

    assign wsel    = fx_wr && (fx_waddr[21:16] == dev_id);
    assign rsel    = fx_rd && (fx_raddr[21:16] == dev_id);
    assign woff    = fx_waddr[15:0];
    assign mode_wr = wsel && (woff == REG_MODE);

`ifdef AD_EMU_NOISE_EN
    logic [3:0] noise_mask;

    always_ff @(posedge clk_sys) begin
        if (!rst_n)                          noise_mask <= '0;
        else if (wsel && woff == REG_NOISE)  noise_mask <= fx_data[3:0];
    end
`endif

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            mode_reg  <= MODE_CONST;
            step_reg  <= '0;
            const_reg <= '0;
        end else if (wsel) begin
            case (woff)
                REG_MODE:     mode_reg        <= fx_data[1:0];
                REG_STEP_LO:  step_reg[7:0]   <= fx_data;
                REG_STEP_HI:  step_reg[15:8]  <= fx_data;
                REG_CONST_LO: const_reg[7:0]  <= fx_data;
                REG_CONST_HI: const_reg[15:8] <= fx_data;
                default: ;
            endcase
        end
    end

    // A clearing write beats a same-cycle increment.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            abort_cnt <= '0;
        end else begin
            if (wsel && woff == REG_FRAMES) frame_cnt <= '0;
            else if (frame_inc)             frame_cnt <= frame_cnt + 8'd1;
            if (wsel && woff == REG_ABORTS) abort_cnt <= '0;
            else if (abort_inc)             abort_cnt <= abort_cnt + 8'd1;
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (fx_raddr[15:0])
            REG_MODE:     rdata = {6'b0, mode_reg};
            REG_STEP_LO:  rdata = step_reg[7:0];
            REG_STEP_HI:  rdata = step_reg[15:8];
            REG_CONST_LO: rdata = const_reg[7:0];
            REG_CONST_HI: rdata = const_reg[15:8];
            REG_FRAMES:   rdata = frame_cnt;
            REG_ABORTS:   rdata = abort_cnt;
            REG_STATUS:   rdata = {6'b0, cs_s, state != ST_IDLE};
`ifdef AD_EMU_NOISE_EN
            REG_NOISE:    rdata = {4'b0, noise_mask};
`endif
            default:      rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n)     fx_q <= 8'h00;
        else if (rsel)  fx_q <= rdata;
        else if (fx_rd) fx_q <= 8'h00;
    end

    ad_emu_pat #(.DW(DW)) u_pat (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .advance    (advance),
        .clr        (mode_wr),
        .mode       (mode_reg),
        .step       (step_reg),
        .cst        (const_reg),
`ifdef AD_EMU_NOISE_EN
        .noise_mask (noise_mask),
`endif
        .sample     (sample)
    );

endmodule

// File: tb/tb_ad_emu_top.sv
// Bench for ad_emu_top: plays the cs_n/sclk master, captures sdata at each sclk fall
// and checks words and fx registers against a behavioural sample/counter model.
module tb_ad_emu_top;

    localparam int H = 6;

    logic        clk_sys = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs_n = 1'b1;
    logic        sclk = 1'b1;
    logic        sdata;
    logic [21:0] fx_waddr = '0;
    logic        fx_wr = 1'b0;
    logic [7:0]  fx_data = '0;
    logic        fx_rd = 1'b0;
    logic [21:0] fx_raddr = '0;
    logic [7:0]  fx_q;
    logic [5:0]  dev_id = 6'h15;

    always #5 clk_sys = ~clk_sys;

    ad_emu_top dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .cs_n     (cs_n),
        .sclk     (sclk),
        .sdata    (sdata),
        .fx_waddr (fx_waddr),
        .fx_wr    (fx_wr),
        .fx_data  (fx_data),
        .fx_rd    (fx_rd),
        .fx_raddr (fx_raddr),
        .fx_q     (fx_q),
        .dev_id   (dev_id)
    );

    int nvec = 0;
    int nerr = 0;

    logic [1:0]  m_mode;
    logic [15:0] m_step, m_const, m_acc, m_lfsr;
    logic        m_phase;
    logic [3:0]  m_mask;
    logic [7:0]  m_frames, m_aborts;
    logic [63:0] cap;

    task automatic model_reset();
        m_mode = 2'd0; m_step = '0; m_const = '0; m_acc = '0; m_phase = 1'b0;
        m_mask = '0; m_frames = '0; m_aborts = '0; m_lfsr = 16'hACE1;
    endtask

    task automatic model_next(output logic [15:0] s);
        logic [15:0] g;
        case (m_mode)
            2'd1: begin g = m_acc; m_acc = m_acc + m_step; end
            2'd2: begin g = m_phase ? ~m_const : m_const; m_phase = ~m_phase; end
            default: g = m_const;
        endcase
        s = g;
`ifdef AD_EMU_NOISE_EN
        s = g ^ {12'h000, m_lfsr[3:0] & m_mask};
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`endif
    endtask

    task automatic wr(input logic [15:0] off, input logic [7:0] d);
        @(negedge clk_sys);
        fx_waddr = {dev_id, off}; fx_data = d; fx_wr = 1'b1;
        @(negedge clk_sys);
        fx_wr = 1'b0;
        case (off)
            16'h0000: begin m_mode = d[1:0]; m_acc = '0; m_phase = 1'b0; end
            16'h0001: m_step[7:0] = d;
            16'h0002: m_step[15:8] = d;
            16'h0003: m_const[7:0] = d;
            16'h0004: m_const[15:8] = d;
            16'h0005: m_frames = '0;
            16'h0006: m_aborts = '0;
`ifdef AD_EMU_NOISE_EN
            16'h0008: m_mask = d[3:0];
`endif
            default: ;
        endcase
    endtask

    task automatic rd(input logic [5:0] dev, input logic [15:0] off, output logic [7:0] q);
        @(negedge clk_sys);
        fx_raddr = {dev, off}; fx_rd = 1'b1;
        @(negedge clk_sys);
        fx_rd = 1'b0;
        q = fx_q;
    endtask

    task automatic frame_start(output logic [15:0] expw);
        @(negedge clk_sys);
        cs_n = 1'b0; cap = '0;
        model_next(expw);
        repeat (H) @(negedge clk_sys);
    endtask

    task automatic frame_clocks(input int n);
        for (int i = 0; i < n; i++) begin
            cap = {cap[62:0], sdata};
            sclk = 1'b0;
            repeat (H) @(negedge clk_sys);
            sclk = 1'b1;
            repeat (H) @(negedge clk_sys);
        end
    endtask

    task automatic frame_stop();
        cs_n = 1'b1;
        repeat (H + 2) @(negedge clk_sys);
    endtask

    task automatic full_frame(output logic [15:0] expw);
        frame_start(expw);
        frame_clocks(18);
        frame_stop();
        m_frames = m_frames + 8'd1;
    endtask

    task automatic test_reset();
        logic [7:0] q;
        rst_n = 1'b0;
        repeat (4) @(negedge clk_sys);
        nvec++;
        if (sdata !== 1'b0) begin nerr++; $display("FAIL reset_sdata got=%b exp=0", sdata); end
        nvec++;
        if (fx_q !== 8'h00) begin nerr++; $display("FAIL reset_fxq got=%h exp=00", fx_q); end
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk_sys);
        rd(dev_id, 16'h0000, q); nvec++;
        if (q !== 8'h00) begin nerr++; $display("FAIL reset_mode got=%h exp=00", q); end
        rd(dev_id, 16'h0005, q); nvec++;
        if (q !== 8'h00) begin nerr++; $display("FAIL reset_frames got=%h exp=00", q); end
        rd(dev_id, 16'h0007, q); nvec++;
        if (q !== 8'h02) begin nerr++; $display("FAIL reset_status got=%h exp=02", q); end
    endtask

    task automatic test_const();
        logic [15:0] e;
        logic [7:0] q;
        wr(16'h0003, 8'h5A);
        wr(16'h0004, 8'hA5);
        nvec++;
        if (sdata !== 1'b0) begin nerr++; $display("FAIL const_idle_before got=%b exp=0", sdata); end
        full_frame(e);
        nvec++;
        if (cap[17:0] !== {2'b00, e} || e !== 16'hA55A)
            begin nerr++; $display("FAIL const_word got=%h exp=%h", cap[17:0], {2'b00, 16'hA55A}); end
        nvec++;
        if (sdata !== 1'b0) begin nerr++; $display("FAIL const_idle_after got=%b exp=0", sdata); end
        rd(dev_id, 16'h0005, q); nvec++;
        if (q !== 8'h01) begin nerr++; $display("FAIL const_frames got=%h exp=01", q); end
    endtask

    task automatic test_ramp();
        logic [15:0] e;
        logic [7:0] q;
        wr(16'h0001, 8'h03); wr(16'h0002, 8'h00); wr(16'h0000, 8'h01);
        for (int k = 0; k < 5; k++) begin
            full_frame(e);
            nvec++;
            if (cap[17:0] !== {2'b00, e} || e !== 16'(3 * k))
                begin nerr++; $display("FAIL ramp3_word%0d got=%h exp=%h", k, cap[17:0], 16'(3 * k)); end
        end
        wr(16'h0001, 8'h00); wr(16'h0002, 8'h80); wr(16'h0000, 8'h01);
        for (int k = 0; k < 3; k++) begin
            full_frame(e);
            nvec++;
            if (cap[17:0] !== {2'b00, e})
                begin nerr++; $display("FAIL ramp8000_word%0d got=%h exp=%h", k, cap[17:0], e); end
        end
        rd(dev_id, 16'h0005, q); nvec++;
        if (q !== m_frames) begin nerr++; $display("FAIL ramp_frames got=%h exp=%h", q, m_frames); end
    endtask

    task automatic test_toggle();
        logic [15:0] e;
        wr(16'h0003, 8'hFF); wr(16'h0004, 8'h00); wr(16'h0000, 8'h02);
        for (int k = 0; k < 3; k++) begin
            full_frame(e);
            nvec++;
            if (cap[17:0] !== {2'b00, e} || e !== ((k % 2) == 1 ? 16'hFF00 : 16'h00FF))
                begin nerr++; $display("FAIL toggle_word%0d got=%h exp=%h", k, cap[17:0], e); end
        end
    endtask

    task automatic test_abort();
        logic [15:0] e;
        logic [7:0] q, f0;
        wr(16'h0001, 8'hFF); wr(16'h0002, 8'hFF); wr(16'h0000, 8'h01);
        wr(16'h0006, 8'h00);
        full_frame(e);
        nvec++;
        if (cap[17:0] !== {2'b00, e}) begin nerr++; $display("FAIL abort_pre_word got=%h exp=%h", cap[17:0], e); end
        f0 = m_frames;
        frame_start(e);
        frame_clocks(7);
        nvec++;
        if (sdata !== e[10]) begin nerr++; $display("FAIL abort_bit_before got=%b exp=%b", sdata, e[10]); end
        cs_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        nvec++;
        if (sdata !== e[10]) begin nerr++; $display("FAIL abort_latency_early got=%b exp=%b", sdata, e[10]); end
        @(negedge clk_sys);
        nvec++;
        if (sdata !== 1'b0) begin nerr++; $display("FAIL abort_sdata got=%b exp=0", sdata); end
        repeat (H) @(negedge clk_sys);
        m_aborts = m_aborts + 8'd1;
        rd(dev_id, 16'h0006, q); nvec++;
        if (q !== 8'h01) begin nerr++; $display("FAIL abort_cnt got=%h exp=01", q); end
        rd(dev_id, 16'h0005, q); nvec++;
        if (q !== f0) begin nerr++; $display("FAIL abort_frames got=%h exp=%h", q, f0); end
        full_frame(e);
        nvec++;
        if (cap[17:0] !== {2'b00, e} || e !== 16'hFFFE)
            begin nerr++; $display("FAIL abort_next_word got=%h exp=%h", cap[17:0], {2'b00, 16'hFFFE}); end
    endtask

    task automatic test_midframe();
        logic [15:0] e;
        logic [7:0] q;
        wr(16'h0000, 8'h00); wr(16'h0003, 8'h5A); wr(16'h0004, 8'hA5);
        frame_start(e);
        frame_clocks(5);
        wr(16'h0003, 8'h34); wr(16'h0004, 8'h12);
        frame_clocks(13);
        frame_stop();
        m_frames = m_frames + 8'd1;
        nvec++;
        if (cap[17:0] !== {2'b00, e} || e !== 16'hA55A)
            begin nerr++; $display("FAIL mid_current got=%h exp=%h", cap[17:0], {2'b00, 16'hA55A}); end
        full_frame(e);
        nvec++;
        if (cap[17:0] !== {2'b00, e} || e !== 16'h1234)
            begin nerr++; $display("FAIL mid_next got=%h exp=%h", cap[17:0], {2'b00, 16'h1234}); end
        rd(dev_id, 16'h0005, q); nvec++;
        if (q !== m_frames) begin nerr++; $display("FAIL mid_frames_sel got=%h exp=%h", q, m_frames); end
        rd(dev_id ^ 6'h01, 16'h0005, q); nvec++;
        if (q !== 8'h00) begin nerr++; $display("FAIL mid_unsel_read got=%h exp=00", q); end
        wr(16'h0005, 8'h00);
        rd(dev_id, 16'h0005, q); nvec++;
        if (q !== 8'h00) begin nerr++; $display("FAIL frames_clear got=%h exp=00", q); end
        wr(16'h0008, 8'h0F);
        rd(dev_id, 16'h0008, q); nvec++;
        if (q !== {4'h0, m_mask}) begin nerr++; $display("FAIL noise_reg got=%h exp=%h", q, {4'h0, m_mask}); end
        wr(16'h0008, 8'h00);
    endtask

    task automatic test_random();
        logic [15:0] e;
        logic [7:0] q;
        int n;
        for (int it = 0; it < 6; it++) begin
            wr(16'h0001, 8'($urandom)); wr(16'h0002, 8'($urandom));
            wr(16'h0003, 8'($urandom)); wr(16'h0004, 8'($urandom));
            wr(16'h0000, 8'($urandom));
            rd(dev_id, 16'h0000, q); nvec++;
            if (q !== {6'b0, m_mode}) begin nerr++; $display("FAIL rnd_mode got=%h exp=%h", q, {6'b0, m_mode}); end
            rd(dev_id, 16'h0002, q); nvec++;
            if (q !== m_step[15:8]) begin nerr++; $display("FAIL rnd_step_hi got=%h exp=%h", q, m_step[15:8]); end
            rd(dev_id, 16'h0003, q); nvec++;
            if (q !== m_const[7:0]) begin nerr++; $display("FAIL rnd_const_lo got=%h exp=%h", q, m_const[7:0]); end
            for (int f = 0; f < 3; f++) begin
                n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 17)) : 18;
                frame_start(e);
                frame_clocks(n);
                frame_stop();
                if (n == 18) begin
                    m_frames = m_frames + 8'd1;
                    nvec++;
                    if (cap[17:0] !== {2'b00, e})
                        begin nerr++; $display("FAIL rnd_word it%0d f%0d got=%h exp=%h", it, f, cap[17:0], e); end
                end else begin
                    m_aborts = m_aborts + 8'd1;
                end
            end
            rd(dev_id, 16'h0005, q); nvec++;
            if (q !== m_frames) begin nerr++; $display("FAIL rnd_frames got=%h exp=%h", q, m_frames); end
            rd(dev_id, 16'h0006, q); nvec++;
            if (q !== m_aborts) begin nerr++; $display("FAIL rnd_aborts got=%h exp=%h", q, m_aborts); end
        end
    endtask

`ifdef AD_EMU_NOISE_EN
    task automatic test_noise();
        logic [15:0] e;
        wr(16'h0008, 8'h0F); wr(16'h0000, 8'h00);
        wr(16'h0003, 8'h00); wr(16'h0004, 8'h10);
        for (int k = 0; k < 4; k++) begin
            full_frame(e);
            nvec++;
            if (cap[17:0] !== {2'b00, e} || cap[15:4] !== 12'h100)
                begin nerr++; $display("FAIL noise_word%0d got=%h exp=%h", k, cap[17:0], e); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_const();
        test_ramp();
        test_toggle();
        test_abort();
        test_midframe();
        test_random();
`ifdef AD_EMU_NOISE_EN
        test_noise();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
